// File: rtl/gpu_vram_arbiter.sv
// gpu_vram_arbiter: single-port framebuffer VRAM controller.
// Shares one RAM port between the CPU bus and the scanout prefetcher.
//
// Ports:
//   clk_bus, rst_n                     clock, async active-low reset
//   bus_read/bus_write/bus_address     CPU bus request (held until !bus_stall)
//   bus_data_i/bus_data_o/bus_stall    CPU bus data and wait handshake
//   fetch_req/fetch_addr/fetch_ack     scanout word request and grant
//   fetch_rvalid/fetch_rdata           scanout data, one cycle after grant
//   frame_start                        loads the pending scroll offset
//   vram_addr/vram_we/vram_wdata       RAM port, combinational from grant
//   vram_rdata                         RAM read data, one cycle latency
module gpu_vram_arbiter #(
  parameter int          FB_WORDS        = 15000,
  parameter int          STARVE_MAX      = 3,
  parameter logic [23:0] REG_OFFSET_ADDR = 24'h050000
) (
  input  logic        clk_bus,
  input  logic        rst_n,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [23:0] bus_address,
  input  logic [31:0] bus_data_i,
  output logic        bus_stall,
  output logic [31:0] bus_data_o,
  input  logic        fetch_req,
  input  logic [13:0] fetch_addr,
  output logic        fetch_ack,
  output logic        fetch_rvalid,
  output logic [31:0] fetch_rdata,
  input  logic        frame_start,
  output logic [13:0] vram_addr,
  output logic        vram_we,
  output logic [31:0] vram_wdata,
  input  logic [31:0] vram_rdata
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [14:0]   FBW  = 15'(FB_WORDS);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic {IDLE, RD_DATA} state_t;
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_VRAM,
    SRC_REG
  } src_t;

  state_t        state, state_nx;
  src_t          rd_src, rd_src_nx;
  logic [13:0]   pending_off, active_off;
  logic [CW-1:0] starve_cnt, starve_nx;
  logic [31:0]   data_q;
  logic          rvalid_q;
  logic [31:0]   rd_val;

  logic [13:0] bus_word;
  logic        vram_hit, reg_hit;
  logic        bus_req, vram_req;
  logic        starved, bus_grant, fetch_grant;
  logic [14:0] sum, phys;
  logic        unused_addr;

  assign bus_word    = bus_address[15:2];
  assign unused_addr = ^bus_address[1:0];
  assign vram_hit    = (bus_address[23:16] == 8'd0)
                    && ({1'b0, bus_word} < FBW);
  assign reg_hit     = (bus_address == REG_OFFSET_ADDR);

  // A request only counts as new in IDLE; in RD_DATA it is completing.
  assign bus_req  = rst_n && (bus_read || bus_write)
                 && (state == IDLE);
  assign vram_req = bus_req && vram_hit;
  assign starved  = (starve_cnt == SMAX);

  assign bus_grant   = vram_req && (!fetch_req || starved);
  assign fetch_grant = rst_n && fetch_req && !bus_grant;

  // Scroll translation with wrap at the end of the frame.
  assign sum  = {1'b0, fetch_addr} + {1'b0, active_off};
  assign phys = (sum >= FBW) ? (sum - FBW) : sum;

  assign vram_addr  = bus_grant   ? bus_word   :
                      fetch_grant ? phys[13:0] : 14'd0;
  assign vram_we    = bus_grant && bus_write;
  assign vram_wdata = bus_data_i;

  assign fetch_ack    = fetch_grant;
  assign fetch_rvalid = rvalid_q;
  assign fetch_rdata  = rvalid_q ? vram_rdata : 32'd0;

  always_comb begin
    state_nx   = state;
    rd_src_nx  = rd_src;
    starve_nx  = starve_cnt;
    bus_stall  = 1'b0;
    bus_data_o = data_q;
    rd_val     = 32'd0;
    unique case (state)
      IDLE: begin
        if (bus_req) begin
          if (bus_write) begin
            bus_stall = vram_hit && !bus_grant;
          end else begin
            bus_stall = 1'b1;
            // Non-VRAM reads never wait for the port.
            if (!vram_hit || bus_grant) begin
              state_nx  = RD_DATA;
              rd_src_nx = vram_hit ? SRC_VRAM :
                          reg_hit  ? SRC_REG  : SRC_ZERO;
            end
          end
        end
        if (!vram_req || bus_grant)
          starve_nx = '0;
        else if (fetch_grant && !starved)
          starve_nx = starve_cnt + 1'b1;
      end
      RD_DATA: begin
        state_nx  = IDLE;
        starve_nx = '0;
        unique case (1'b1)
          (rd_src == SRC_VRAM): rd_val = vram_rdata;
          (rd_src == SRC_REG):  rd_val = {18'd0, pending_off};
          default:              rd_val = 32'd0;
        endcase
        bus_data_o = rd_val;
      end
    endcase
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_src      <= SRC_ZERO;
      starve_cnt  <= '0;
      pending_off <= 14'd0;
      active_off  <= 14'd0;
      data_q      <= 32'd0;
      rvalid_q    <= 1'b0;
    end else begin
      state      <= state_nx;
      rd_src     <= rd_src_nx;
      starve_cnt <= starve_nx;
      rvalid_q   <= fetch_grant;
      if (state == RD_DATA)
        data_q <= rd_val;
      if (bus_req && bus_write && reg_hit
          && (bus_data_i < 32'(FB_WORDS)))
        pending_off <= bus_data_i[13:0];
      // Old pending value wins over a same-cycle register write.
      if (frame_start)
        active_off <= pending_off;
    end
  end

endmodule

// File: tb/tb_gpu_vram_arbiter.sv
// tb_gpu_vram_arbiter: directed scenarios plus randomized traffic
// checked against a rule-level model of the arbiter.
module tb_gpu_vram_arbiter;

  localparam int          FB  = 15000;
  localparam int          SM  = 3;
  localparam logic [23:0] REG = 24'h050000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_read, bus_write;
  logic [23:0] bus_address;
  logic [31:0] bus_data_i, bus_data_o;
  logic        bus_stall;
  logic        fetch_req, fetch_ack, fetch_rvalid;
  logic [13:0] fetch_addr;
  logic [31:0] fetch_rdata;
  logic        frame_start;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [31:0] vram_wdata, vram_rdata;

  gpu_vram_arbiter #(
    .FB_WORDS(FB),
    .STARVE_MAX(SM),
    .REG_OFFSET_ADDR(REG)
  ) dut (
    .clk_bus(clk),
    .rst_n(rst_n),
    .bus_read(bus_read),
    .bus_write(bus_write),
    .bus_address(bus_address),
    .bus_data_i(bus_data_i),
    .bus_stall(bus_stall),
    .bus_data_o(bus_data_o),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack),
    .fetch_rvalid(fetch_rvalid),
    .fetch_rdata(fetch_rdata),
    .frame_start(frame_start),
    .vram_addr(vram_addr),
    .vram_we(vram_we),
    .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM behind the controller.
  logic [31:0] ram [16384];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (vram_we) ram[vram_addr] <= vram_wdata;
    ram_q <= ram[vram_addr];
  end
  assign vram_rdata = ram_q;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model state
  logic [31:0] shadow [int];
  int          pend, act, pend_new;
  bit          txn, t_wr, t_both, ph2;
  int          t_cyc, k, w, ph, p;
  logic [23:0] t_addr;
  logic [31:0] t_data, exp_rd;
  bit          hit, isreg, blocked, gr, exp_stall, exp_ack;
  bit          prev_ack, exp_known, rd_known;
  logic [31:0] exp_f;

  initial begin
    rst_n = 1'b0;
    bus_read = 0; bus_write = 0; bus_address = 0; bus_data_i = 0;
    fetch_req = 0; fetch_addr = 0; frame_start = 0;
    repeat (2) tick();
    #1;
    check("rst_stall", bus_stall, 0);
    check("rst_ack", fetch_ack, 0);
    check("rst_we", vram_we, 0);
    check("rst_addr", vram_addr, 0);
    check("rst_rdo", bus_data_o, 0);
    check("rst_rvalid", fetch_rvalid, 0);
    check("rst_rdata", fetch_rdata, 0);
    tick();
    rst_n = 1'b1;

    // Uncontended write, zero wait states
    bus_write = 1; bus_address = 0; bus_data_i = 32'haaaaaaaa;
    #1;
    check("w0_we", vram_we, 1);
    check("w0_addr", vram_addr, 0);
    check("w0_stall", bus_stall, 0);
    tick(); shadow[0] = 32'haaaaaaaa;

    // Last framebuffer word, write then read
    bus_address = 24'h00EA5C; bus_data_i = 32'h55555555;
    #1; check("wlast_stall", bus_stall, 0);
    tick(); shadow[14999] = 32'h55555555;
    bus_write = 0; bus_read = 1;
    #1;
    check("rlast_stall0", bus_stall, 1);
    check("rlast_addr", vram_addr, 14999);
    tick(); #1;
    check("rlast_stall1", bus_stall, 0);
    check("rlast_data", bus_data_o, 32'h55555555);
    tick(); bus_read = 0;
    #1; check("rlast_hold", bus_data_o, 32'h55555555);
    tick();

    // Scroll offset
    bus_write = 1; bus_address = REG; bus_data_i = 50;
    #1; check("off_stall", bus_stall, 0);
    tick(); bus_write = 0;
    fetch_req = 1; fetch_addr = 0;
    #1;
    check("f0_ack", fetch_ack, 1);
    check("f0_addr", vram_addr, 0);
    tick(); fetch_req = 0; frame_start = 1;
    #1;
    check("f0_rvalid", fetch_rvalid, 1);
    check("f0_rdata", fetch_rdata, 32'haaaaaaaa);
    tick(); frame_start = 0;
    fetch_req = 1; fetch_addr = 0;
    #1;
    check("f50_rvalid", fetch_rvalid, 0);
    check("f50_addr", vram_addr, 50);
    tick(); fetch_addr = 14990;
    #1;
    check("f40_rvalid", fetch_rvalid, 1);
    check("f40_addr", vram_addr, 40);
    tick(); fetch_addr = 14949;
    #1; check("fwrap_addr", vram_addr, 14999);
    tick(); fetch_req = 0;
    #1;
    check("fwrap_rvalid", fetch_rvalid, 1);
    check("fwrap_rdata", fetch_rdata, 32'h55555555);
    tick();

    // Starvation guard, twice to show the counter clears
    for (int r = 0; r < 2; r++) begin
      fetch_req = 1; fetch_addr = 0;
      bus_write = 1; bus_address = 24'h4; bus_data_i = 32'h1234;
      for (int i = 0; i < 4; i++) begin
        #1;
        check("starve_stall", bus_stall, (i < 3));
        check("starve_ack", fetch_ack, (i < 3));
        tick();
      end
      bus_write = 0;
      #1; check("starve_after", fetch_ack, 1);
      tick();
    end
    fetch_req = 0; shadow[1] = 32'h1234;
    tick();

    // Oversized offset ignored, out-of-range VRAM
    bus_write = 1; bus_address = REG; bus_data_i = 15000;
    #1; check("big_stall", bus_stall, 0);
    tick(); bus_write = 0; bus_read = 1;
    #1; check("reg_rd_s0", bus_stall, 1);
    tick(); #1;
    check("reg_rd_s1", bus_stall, 0);
    check("reg_rd", bus_data_o, 50);
    tick(); bus_read = 0;
    bus_write = 1; bus_address = 24'h00EA60; bus_data_i = 32'hdeadbeef;
    #1;
    check("oor_we", vram_we, 0);
    check("oor_stall", bus_stall, 0);
    tick(); bus_write = 0; bus_read = 1;
    #1; check("oor_rd_s0", bus_stall, 1);
    tick(); #1;
    check("oor_rd_s1", bus_stall, 0);
    check("oor_rd", bus_data_o, 0);
    tick(); bus_read = 0;

    // Reset during RD_DATA
    bus_read = 1; bus_address = 0;
    #1; check("rr_s0", bus_stall, 1);
    tick(); rst_n = 0;
    #1;
    check("rr_stall", bus_stall, 0);
    check("rr_rdo", bus_data_o, 0);
    tick(); bus_read = 0;
    tick(); rst_n = 1;
    fetch_req = 1; fetch_addr = 0;
    #1; check("rr_act", vram_addr, 0);
    tick(); fetch_req = 0;
    bus_read = 1; bus_address = 0;
    #1; check("rr2_s0", bus_stall, 1);
    tick(); #1;
    check("rr2_s1", bus_stall, 0);
    check("rr2_data", bus_data_o, 32'haaaaaaaa);
    tick(); bus_read = 0;
    tick();

    // Randomized traffic
    pend = 0; act = 0; txn = 0; ph2 = 0; t_cyc = 0;
    prev_ack = 0; exp_known = 0; exp_f = 0;
    t_wr = 0; t_both = 0; t_addr = 0; t_data = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!txn && $urandom_range(0, 2) != 0) begin
        txn = 1; ph2 = 0; t_cyc = 0;
        t_wr = ($urandom_range(0, 1) == 1);
        t_both = t_wr && ($urandom_range(0, 3) == 0);
        t_data = $urandom;
        k = $urandom_range(0, 9);
        if (k < 6)
          t_addr = 24'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
        else if (k == 6)
          t_addr = 24'($urandom_range(0, FB - 1) * 4);
        else if (k == 7)
          t_addr = REG;
        else if (k == 8)
          t_addr = 24'($urandom_range(FB, 16383) * 4);
        else
          t_addr = {8'($urandom_range(1, 255)), 16'($urandom)};
        if (t_addr == REG && $urandom_range(0, 1) == 1)
          t_data = 32'($urandom_range(0, FB - 1));
      end
      bus_write = txn && t_wr;
      bus_read = txn && (!t_wr || t_both);
      bus_address = t_addr;
      bus_data_i = t_data;
      fetch_req = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) begin
        p = $urandom_range(0, 63);
        fetch_addr = 14'((p + FB - act) % FB);
      end else begin
        fetch_addr = 14'($urandom_range(0, FB - 1));
      end
      frame_start = ($urandom_range(0, 49) == 0);
      #1;

      check("rvalid", fetch_rvalid, prev_ack);
      if (prev_ack && exp_known)
        check("fetch_rdata", fetch_rdata, exp_f);

      hit = (t_addr[23:16] == 8'd0) && (int'(t_addr[15:2]) < FB);
      isreg = (t_addr == REG);
      w = int'(t_addr[15:2]);
      blocked = txn && hit && fetch_req && (t_cyc < SM);
      gr = txn && hit && (t_wr || !ph2) && !blocked;
      exp_stall = txn && (t_wr ? blocked : !ph2);
      exp_ack = fetch_req && !gr;

      check("bus_stall", bus_stall, exp_stall);
      check("fetch_ack", fetch_ack, exp_ack);
      check("vram_we", vram_we, gr && t_wr);
      if (gr)
        check("bus_addr", vram_addr, w);
      if (fetch_ack) begin
        ph = (int'(fetch_addr) + act) % FB;
        check("phys", vram_addr, ph);
        exp_known = shadow.exists(ph);
        if (exp_known) exp_f = shadow[ph];
      end
      prev_ack = fetch_ack;

      if (txn && !t_wr && ph2) begin
        rd_known = 1;
        if (hit) begin
          rd_known = shadow.exists(w);
          exp_rd = rd_known ? shadow[w] : 32'd0;
        end else if (isreg) begin
          exp_rd = 32'(pend);
        end else begin
          exp_rd = 32'd0;
        end
        if (rd_known) check("rd_data", bus_data_o, exp_rd);
      end

      pend_new = pend;
      if (txn) begin
        if (t_wr) begin
          if (!blocked) begin
            if (hit) shadow[w] = t_data;
            else if (isreg && t_data < 32'(FB)) pend_new = int'(t_data);
            txn = 0;
          end else begin
            t_cyc++;
          end
        end else if (!ph2) begin
          if (blocked) t_cyc++;
          else ph2 = 1;
        end else begin
          txn = 0; ph2 = 0;
        end
      end
      if (frame_start) act = pend;
      pend = pend_new;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
